// File: rtl/sdlc_deframer.sv
// SDLC receive deframer: flag/abort detection, zero-bit unstuffing, byte assembly.
// Define SDLC_NRZI_EN to decode NRZI line bits before deframing.
module sdlc_deframer #(
  parameter int MIN_BYTES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_en,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic       rx_err
);

  localparam int BCW = (MIN_BYTES < 1) ? 1 : $clog2(MIN_BYTES + 1);
  localparam logic [BCW-1:0] MINB = BCW'(MIN_BYTES);

  typedef enum logic {HUNT, FRAME} state_t;

  state_t         state, state_nx;
  logic [2:0]     ones_cnt;
  logic [2:0]     bit_cnt;
  logic [BCW-1:0] byte_cnt;
  logic [7:0]     shreg;
  logic [7:0]     hold;
  logic           hold_full;
  logic           first;
  logic           dec;
  logic           flag, abort, stuff, data;
  logic           pending;
  logic [7:0]     sh_nx;

`ifdef SDLC_NRZI_EN
  logic nrzi_ref;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       nrzi_ref <= 1'b1;
    else if (bit_en) nrzi_ref <= bit_in;
  end

  assign dec = (bit_in == nrzi_ref);
`else
  assign dec = bit_in;
`endif

  assign sh_nx = {dec, shreg[7:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_nx;
  end

  always_comb begin
    flag     = 1'b0;
    abort    = 1'b0;
    stuff    = 1'b0;
    data     = 1'b0;
    pending  = hold_full || (byte_cnt != '0);
    state_nx = state;
    if (bit_en) begin
      flag  = !dec && (ones_cnt == 3'd6);
      abort =  dec && (ones_cnt == 3'd6);
      stuff = !dec && (ones_cnt == 3'd5);
      unique case (state)
        HUNT: if (flag) state_nx = FRAME;
        FRAME: begin
          if (abort) state_nx = HUNT;
          data = !flag && !abort && !stuff;
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      first     <= 1'b0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      rx_sof    <= 1'b0;
      rx_eof    <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      rx_err   <= 1'b0;
      if (bit_en) begin
        if (!dec)                   ones_cnt <= '0;
        else if (ones_cnt != 3'd7)  ones_cnt <= ones_cnt + 3'd1;
        unique case (1'b1)
          flag: begin
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            hold_full <= 1'b0;
            first     <= 1'b1;
            if (state == FRAME) begin
              // Flag's leading 0111111 landed in the assembler: a clean
              // close leaves exactly seven bits after the held byte.
              if (bit_cnt == 3'd7 && hold_full) begin
                rx_byte  <= hold;
                rx_valid <= 1'b1;
                rx_sof   <= first;
                rx_eof   <= 1'b1;
                rx_err   <= (byte_cnt < MINB);
              end else if (pending) begin
                rx_err <= 1'b1;
              end
            end
          end
          abort: begin
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            hold_full <= 1'b0;
            if (state == FRAME && pending) rx_err <= 1'b1;
          end
          data: begin
            shreg   <= sh_nx;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              hold      <= sh_nx;
              hold_full <= 1'b1;
              if (byte_cnt != MINB) byte_cnt <= byte_cnt + BCW'(1);
              if (hold_full) begin
                rx_byte  <= hold;
                rx_valid <= 1'b1;
                rx_sof   <= first;
                first    <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdlc_deframer.sv
// Directed bench for sdlc_deframer; two instances (MIN_BYTES=4 and 1).
// Line encoding follows SDLC_NRZI_EN so the same vectors serve both builds.
module tb_sdlc_deframer;

  logic       stim_clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_en = 1'b0;
  logic [7:0] b4, b1;
  logic       v4, s4, e4, r4;
  logic       v1, s1, e1, r1;

  int   checks = 0;
  int   errors = 0;
  int   bit_no = 0;
  int   eof_stamp = -1;
  int   tones = 0;
  logic line_prev = 1'b1;

  logic [11:0] q4[$];
  logic [11:0] q1[$];

  always #5 stim_clk = ~stim_clk;

  sdlc_deframer #(.MIN_BYTES(4)) dut4 (
    .clk(stim_clk), .reset(reset), .bit_in(bit_in), .bit_en(bit_en),
    .rx_byte(b4), .rx_valid(v4), .rx_sof(s4), .rx_eof(e4), .rx_err(r4)
  );

  sdlc_deframer #(.MIN_BYTES(1)) dut1 (
    .clk(stim_clk), .reset(reset), .bit_in(bit_in), .bit_en(bit_en),
    .rx_byte(b1), .rx_valid(v1), .rx_sof(s1), .rx_eof(e1), .rx_err(r1)
  );

  always @(negedge stim_clk) begin
    if (v4 || r4) q4.push_back({v4, s4, e4, r4, b4});
    if (v4 && e4) eof_stamp = bit_no;
    if (v1 || r1) q1.push_back({v1, s1, e1, r1, b1});
  end

  function automatic logic [11:0] ev(input logic v, input logic s,
                                     input logic e, input logic r,
                                     input logic [7:0] b);
    return {v, s, e, r, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input string tag, input bit sel,
                           input logic [11:0] exp);
    logic [11:0] o;
    o = 'x;
    if (!sel && q4.size() > 0) o = q4.pop_front();
    if (sel && q1.size() > 0)  o = q1.pop_front();
    check(tag, {20'd0, o}, {20'd0, exp});
  endtask

  task automatic expect_none(input string tag, input bit sel);
    check(tag, sel ? q1.size() : q4.size(), 0);
  endtask

  task automatic tx(input logic d);
    bit_no++;
`ifdef SDLC_NRZI_EN
    bit_in = d ? line_prev : ~line_prev;
    line_prev = bit_in;
`else
    bit_in = d;
`endif
    bit_en = 1'b1;
    @(negedge stim_clk);
    bit_en = 1'b0;
    @(negedge stim_clk);
  endtask

  task automatic data_bit(input logic d);
    tx(d);
    if (d) begin
      tones++;
      if (tones == 5) begin
        tx(1'b0);
        tones = 0;
      end
    end else begin
      tones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) data_bit(b[i]);
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) tx(f[i]);
    tones = 0;
  endtask

  task automatic good_frame();
    send_flag();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_flag();
  endtask

  task automatic expect_good(input string tag);
    expect_ev({tag, "_b1"}, 1'b0, ev(1, 1, 0, 0, 8'h01));
    expect_ev({tag, "_b2"}, 1'b0, ev(1, 0, 0, 0, 8'h02));
    expect_ev({tag, "_b3"}, 1'b0, ev(1, 0, 0, 0, 8'h03));
    expect_ev({tag, "_b4"}, 1'b0, ev(1, 0, 1, 0, 8'h04));
    expect_none({tag, "_end"}, 1'b0);
  endtask

  initial begin
    @(negedge stim_clk);
    @(negedge stim_clk);
    check("rst_out4", {v4, s4, e4, r4, b4}, 0);
    check("rst_out1", {v1, s1, e1, r1, b1}, 0);
    reset = 1'b0;
    @(negedge stim_clk);

    // four-byte good frame, eof one clk after the closing flag bit
    good_frame();
    expect_good("good");
    check("eof_latency", eof_stamp, bit_no);
    repeat (4) @(negedge stim_clk);
    check("byte_hold", {24'd0, b4}, 32'h04);
    check("valid_low", v4, 0);

    // single stuffed byte, short for MIN_BYTES=4 only
    q1.delete();
    send_flag();
    send_byte(8'h1F);
    send_flag();
    expect_ev("short4", 1'b0, ev(1, 1, 1, 1, 8'h1F));
    expect_none("short4_end", 1'b0);
    expect_ev("short1", 1'b1, ev(1, 1, 1, 0, 8'h1F));
    expect_none("short1_end", 1'b1);

    // abort after two bytes, then junk ignored in HUNT
    send_flag();
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (10) tx(1'b1);
    send_byte(8'h00);
    send_byte(8'h5A);
    expect_ev("abort_aa", 1'b0, ev(1, 1, 0, 0, 8'hAA));
    expect_ev("abort_err", 1'b0, ev(0, 0, 0, 1, 8'hAA));
    expect_none("abort_hunt", 1'b0);

    // misaligned close: three extra bits before the flag
    send_flag();
    send_byte(8'hAA);
    data_bit(1'b0);
    data_bit(1'b1);
    data_bit(1'b0);
    send_flag();
    expect_ev("misalign_aa", 1'b0, ev(1, 1, 0, 0, 8'hAA));
    expect_ev("misalign_err", 1'b0, ev(0, 0, 0, 1, 8'hAA));
    expect_none("misalign_end", 1'b0);

    // idle flags then a four-byte frame
    send_flag();
    send_flag();
    send_flag();
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    send_flag();
    expect_ev("idle_55", 1'b0, ev(1, 1, 0, 0, 8'h55));
    expect_ev("idle_66", 1'b0, ev(1, 0, 0, 0, 8'h66));
    expect_ev("idle_77", 1'b0, ev(1, 0, 0, 0, 8'h77));
    expect_ev("idle_88", 1'b0, ev(1, 0, 1, 0, 8'h88));
    expect_none("idle_end", 1'b0);

    // reset between byte 2 and byte 3
    send_flag();
    send_byte(8'h01);
    send_byte(8'h02);
    reset = 1'b1;
    #1;
    check("midrst_async", {v4, s4, e4, r4, b4}, 0);
    @(negedge stim_clk);
    @(negedge stim_clk);
    check("midrst_hold", {v4, s4, e4, r4, b4}, 0);
    reset = 1'b0;
    line_prev = 1'b1;
    tones = 0;
    @(negedge stim_clk);
    expect_ev("midrst_b1", 1'b0, ev(1, 1, 0, 0, 8'h01));
    expect_none("midrst_noerr", 1'b0);
    good_frame();
    expect_good("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdlc_deframer.md
SDLC_DEFRAMER -- requirements
Module: sdlc_deframer

Interface
REQ-001 SHALL have parameter MIN_BYTES, default 4: minimum good-frame length in bytes, counting FCS.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port bit_in  input  1  recovered line bit from the DPLL stage.
REQ-005 SHALL have port bit_en  input  1  one-clk strobe; bit_in is valid when bit_en is high.
REQ-006 SHALL have port rx_byte  output  8  received byte, LSB first on the line.
REQ-007 SHALL have port rx_valid  output  1  one-clk pulse; rx_byte is valid.
REQ-008 SHALL have port rx_sof  output  1  high with rx_valid on the first byte of a frame.
REQ-009 SHALL have port rx_eof  output  1  high with rx_valid on the last byte of a frame.
REQ-010 SHALL have port rx_err  output  1  one-clk pulse; the current frame is bad or aborted.

Function
REQ-011 SHALL do no processing on a clk edge when bit_en is low, and SHALL hold all state.
REQ-012 SHALL keep ones_cnt (0..7, saturating at 7): increment on decoded 1, clear on decoded 0.
REQ-013 SHALL detect a flag on decoded 0 with ones_cnt==6.
REQ-014 SHALL detect an abort on decoded 1 with ones_cnt==6; at 7, further 1s SHALL give no new abort.
REQ-015 SHALL discard a stuffed zero (decoded 0 with ones_cnt==5) without counting or shifting it.
REQ-016 SHALL have states HUNT and FRAME; reset state is HUNT; HUNT ignores all data bits.
REQ-017 SHALL go HUNT->FRAME on a flag; on a flag in FRAME it SHALL stay in FRAME and close the frame; on an abort it SHALL go to HUNT from either state.
REQ-018 In FRAME, SHALL shift each other decoded bit into an 8-bit LSB-first assembler and SHALL increment bit_cnt (3 bits) on it.
REQ-019 On the bit completing 8 bits, SHALL move the assembled byte to a hold register; if the hold register was already full, SHALL first output the old held byte.
REQ-020 On a flag in FRAME with bit_cnt==7 and hold full, SHALL output the held byte with rx_eof=1; it SHALL also pulse rx_err with that byte if frame bytes < MIN_BYTES.
REQ-021 On a flag in FRAME with bytes pending (hold full or byte_cnt>0) and bit_cnt!=7, SHALL drop the held byte and pulse rx_err, with rx_valid low.
REQ-022 On a flag with nothing pending (idle flags, shared-zero flags), SHALL produce no output.
REQ-023 On every flag, SHALL clear bit_cnt, byte_cnt and the hold-full flag.
REQ-024 On an abort in FRAME, SHALL drop the held byte; if bytes were pending it SHALL pulse rx_err, otherwise nothing.
REQ-025 SHALL set rx_sof with the first output byte after a flag.
REQ-026 SHALL saturate byte_cnt at MIN_BYTES.
REQ-027 SHALL register all outputs; latency SHALL be exactly 1 clk after the causing bit_en cycle.
REQ-028 SHALL keep rx_valid, rx_sof, rx_eof and rx_err low in all other cycles; rx_byte SHALL hold its last value.

Reset
REQ-029 Reset SHALL clear rx_byte=0x00, rx_valid=rx_sof=rx_eof=rx_err=0.
REQ-030 Reset SHALL set state=HUNT, ones_cnt=bit_cnt=byte_cnt=0, hold empty, NRZI reference=1.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no rx_err pulse.

Configuration
REQ-032 With SDLC_NRZI_EN defined, decoded SHALL be 1 when bit_in equals the previous bit_in, else 0; the reference SHALL update on each bit_en.
REQ-033 Without SDLC_NRZI_EN, decoded SHALL equal bit_in, and no NRZI register SHALL be synthesised.

Verification
REQ-034 (NRZ) Feed 7E 01 02 03 04 7E -> 4 rx_valid pulses: 01(sof), 02, 03, 04(eof); rx_err never pulses.
REQ-035 (NRZ) Feed 7E 1F 7E, 1F sent as 11111 0(stuffed) 000 -> with MIN_BYTES=1, a single byte 1F with sof and eof; with MIN_BYTES=4, the same byte plus an rx_err pulse.
REQ-036 (NRZ) Feed 7E AA BB then seven or more 1s -> AA output (sof); BB dropped; one rx_err pulse; then HUNT, no output until the next flag.
REQ-037 (NRZ) Feed 7E AA plus 3 extra bits then 7E -> no eof byte; one rx_err pulse.
REQ-038 (SDLC_NRZI_EN) Feed NRZI-encoded 7E 7E 7E 55 66 77 88 7E -> bytes 55(sof) 66 77 88(eof); idle flags produce no output.
REQ-039 Assert reset between byte 2 and byte 3 of REQ-034 -> all outputs 0 within the reset; no rx_err; the next frame is received correctly.
